// File: rtl/riscv_mem_pkg.sv
// -----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared types for the memory responder and any block that has to merge store
// data into a word (for example the core's store-alignment path).
//   mem_state_t : responder control states
//   addr_t      : 32-bit byte address
//   data_t      : 32-bit data word
//   strb_t      : 4-bit byte-lane enables
// -----------------------------------------------------------------------------
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  strb_t;

   localparam int NUM_LANES = 4;

endpackage : riscv_mem_pkg

// File: rtl/mem_byte_merge.sv
// -----------------------------------------------------------------------------
// mem_byte_merge
// Combinational byte-lane merge: every lane whose strobe is set takes the byte
// from wdata_i, every other lane keeps the byte from old_i.
// Ports:
//   old_i    in  32  current word contents
//   wdata_i  in  32  lane-aligned store data
//   wstrb_i  in   4  byte enables, bit i covers bits [8i+7:8i]
//   merged_o out 32  resulting word
// -----------------------------------------------------------------------------
module mem_byte_merge
   import riscv_mem_pkg::*;
(
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wstrb_i[i]) begin
            merged_o[8*i +: 8] = wdata_i[8*i +: 8];
         end
      end
   end

endmodule : mem_byte_merge

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-organised memory answering load/store/fetch requests with a
// configurable number of wait states. The array M[] is a plain unpacked array
// so benches can preload it hierarchically.
//
// Handshake: a transfer happens on a channel at a posedge where both valid and
// ready are high. The request channel is only ready in IDLE, so at most one
// request is outstanding; req_* are ignored whenever req_ready is low. Once
// rsp_valid rises, rsp_valid/rsp_rdata/rsp_err stay stable until the edge with
// rsp_ready high; after it rsp_valid drops and rdata/err keep their values.
//
// Ports:
//   clk       in   1  system clock, posedge
//   reset     in   1  synchronous active-high reset
//   req_valid in   1  request present
//   req_ready out  1  responder idle, can accept
//   req_we    in   1  1 = write, 0 = read
//   req_addr  in  32  byte address
//   req_wdata in  32  lane-aligned write data
//   req_wstrb in   4  byte enables
//   rsp_valid out  1  response available
//   rsp_ready in   1  initiator takes the response
//   rsp_rdata out 32  read data (0 for writes and errors)
//   rsp_err   out  1  misaligned or out-of-range access
// -----------------------------------------------------------------------------
module mem_responder
   import riscv_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   if (LATENCY < 1) begin : g_latency_check
      $error("mem_responder: LATENCY must be at least 1");
   end

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // The counter only ever holds values up to LATENCY-2.
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   data_t M [DEPTH_WORDS];

   mem_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q;
   addr_t            addr_q;
   data_t            wdata_q;
   strb_t            wstrb_q;
   data_t            rdata_q;
   logic             err_q;

   logic             accept;
   logic             commit;
   logic             c_we;
   addr_t            c_addr;
   data_t            c_wdata;
   strb_t            c_wstrb;
   addr_t            off;
   addr_t            word_off;
   logic             acc_err;
   logic             noop_write;
   logic [IDX_W-1:0] idx;
   data_t            old_word;
   data_t            merged_word;

   assign accept = (state_q == IDLE) && req_valid;

   // With LATENCY==1 the commit happens on the accepting edge itself, before
   // the latched copies exist, so IDLE uses the live request fields.
   assign c_we    = (state_q == IDLE) ? req_we    : we_q;
   assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign c_wstrb = (state_q == IDLE) ? req_wstrb : wstrb_q;

   assign off        = c_addr - BASE_ADDR;
   assign word_off   = {2'b00, off[31:2]};
   assign idx        = off[IDX_W+1:2];
   // An all-zero-strobe write touches no lane, so lane alignment is moot.
   assign noop_write = c_we && (c_wstrb == 4'b0000);
   assign acc_err    = (c_addr < BASE_ADDR)
                    || (word_off >= $unsigned(DEPTH_WORDS))
                    || ((c_addr[1:0] != 2'b00) && !noop_write);

   assign old_word = M[idx];

   mem_byte_merge u_merge (
      .old_i    (old_word),
      .wdata_i  (c_wdata),
      .wstrb_i  (c_wstrb),
      .merged_o (merged_word)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign commit = (state_d == RESP) && (state_q != RESP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
         end
         if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || c_we) ? '0 : old_word;
         end
      end
   end

   // The array has no reset: contents survive reset, and a write accepted but
   // not yet committed is simply never performed.
   always_ff @(posedge clk) begin
      if (!reset && commit && c_we && !acc_err) begin
         M[idx] <= merged_word;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders side by side: instance 0 with LATENCY=1, instance 1 with
// LATENCY=4. Expected responses are queued per instance when a request is
// driven and popped by a monitor when the response handshake is seen.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_checks = 0;
   int n_fail   = 0;

   logic [32:0] exp_q0[$];
   logic [32:0] exp_q1[$];
   logic [31:0] mdl [2][DEPTH];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [14];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[0]),
      .req_ready (req_ready[0]),
      .req_we    (req_we[0]),
      .req_addr  (req_addr[0]),
      .req_wdata (req_wdata[0]),
      .req_wstrb (req_wstrb[0]),
      .rsp_valid (rsp_valid[0]),
      .rsp_ready (rsp_ready[0]),
      .rsp_rdata (rsp_rdata[0]),
      .rsp_err   (rsp_err[0])
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[1]),
      .req_ready (req_ready[1]),
      .req_we    (req_we[1]),
      .req_addr  (req_addr[1]),
      .req_wdata (req_wdata[1]),
      .req_wstrb (req_wstrb[1]),
      .rsp_valid (rsp_valid[1]),
      .rsp_ready (rsp_ready[1]),
      .rsp_rdata (rsp_rdata[1]),
      .rsp_err   (rsp_err[1])
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour of one access; updates the model memory.
   function automatic logic [32:0] model_access(input int d, input logic we,
                                                input logic [31:0] addr,
                                                input logic [31:0] wdata,
                                                input logic [3:0] wstrb);
      logic        noop;
      logic        err;
      logic [31:0] widx;
      int          i;
      noop = we && (wstrb == 4'b0000);
      widx = addr >> 2;
      err  = ((addr[1:0] != 2'b00) && !noop) || (widx >= DEPTH);
      if (err) return {1'b1, 32'h0};
      i = int'(widx);
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mdl[d][i][8*b +: 8] = wdata[8*b +: 8];
         return {1'b0, 32'h0};
      end
      return {1'b0, mdl[d][i]};
   endfunction

   task automatic backdoor(input int d, input int idx, input logic [31:0] val);
      mdl[d][idx] = val;
      if (d == 0) u_dut0.M[idx] = val;
      else        u_dut1.M[idx] = val;
   endtask

   task automatic push_exp(input int d, input logic [32:0] e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // Returns at a negedge with req_ready high, or after a bounded wait.
   task automatic wait_idle(input int d);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[d]) ok = 1'b1;
      end
      check("idle_reached", {32'h0, ok}, 33'h1);
   endtask

   // Drives one request and checks rsp_valid timing and req_ready drop.
   task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [32:0] exp);
      int lat;
      lat = (d == 0) ? 1 : 4;
      wait_idle(d);
      push_exp(d, exp);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wstrb[d] = wstrb;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      // Scramble the request fields: only the latched copy may be used.
      req_we[d]    = ~we;
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_wstrb[d] = 4'($urandom_range(0, 15));
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == 1) check("req_ready_low", {32'h0, req_ready[d]}, 33'h0);
         check("rsp_valid_latency", {32'h0, rsp_valid[d]}, {32'h0, (c == lat)});
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [32:0] e;
      if (rsp_valid[0] && rsp_ready[0]) begin
         if (exp_q0.size() == 0) begin
            check("unexpected_rsp0", {rsp_err[0], rsp_rdata[0]}, 33'h1_FFFF_FFFF);
         end else begin
            e = exp_q0.pop_front();
            check("rsp0", {rsp_err[0], rsp_rdata[0]}, e);
         end
      end
      if (rsp_valid[1] && rsp_ready[1]) begin
         if (exp_q1.size() == 0) begin
            check("unexpected_rsp1", {rsp_err[1], rsp_rdata[1]}, 33'h1_FFFF_FFFF);
         end else begin
            e = exp_q1.pop_front();
            check("rsp1", {rsp_err[1], rsp_rdata[1]}, e);
         end
      end
   end

   // ---------------- main test ----------------
   initial begin
      logic [32:0] e;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;

      vecs[0]  = '{1'b1, 32'd8,           32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'd8,           32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'd12,          32'h0000AA00, 4'b0010, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'd12,          32'h0,        4'b0000, 32'h1122AA44, 1'b0};
      vecs[4]  = '{1'b0, 32'd6,           32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[5]  = '{1'b0, 32'(4*DEPTH),    32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[6]  = '{1'b1, 32'd6,           32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
      vecs[7]  = '{1'b1, 32'd2,           32'h12345678, 4'b1111, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 32'd0,           32'h0,        4'b0000, 32'h00115093, 1'b0};
      vecs[9]  = '{1'b0, 32'd12,          32'h0,        4'b0000, 32'h1122AA44, 1'b0};
      vecs[10] = '{1'b1, 32'(4*DEPTH-4),  32'hA5A5A5A5, 4'b1111, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'(4*DEPTH-4),  32'h0,        4'b0000, 32'hA5A5A5A5, 1'b0};
      vecs[12] = '{1'b1, 32'(4*DEPTH),    32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[13] = '{1'b0, 32'd4,           32'h0,        4'b0000, 32'd42,       1'b0};

      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         req_wstrb[d] = '0;
         rsp_ready[d] = 1'b1;
         for (int i = 0; i < DEPTH; i++) backdoor(d, i, 32'h0);
      end

      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("reset_rsp_valid", {32'h0, rsp_valid[d]}, 33'h0);
         check("reset_rsp_rdata", {1'b0, rsp_rdata[d]}, 33'h0);
         check("reset_rsp_err",   {32'h0, rsp_err[d]},   33'h0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_ready0", {32'h0, req_ready[0]}, 33'h1);
      check("post_reset_ready1", {32'h0, req_ready[1]}, 33'h1);

      // Preload through the backdoor
      for (int d = 0; d < 2; d++) begin
         backdoor(d, 0, 32'h00115093);
         backdoor(d, 1, 32'd42);
         backdoor(d, 3, 32'h11223344);
      end

      // LATENCY=1 fetch of M[0]
      do_req(0, 1'b0, 32'd0, 32'h0, 4'h0, model_access(0, 1'b0, 32'd0, 32'h0, 4'h0));

      // Table on the LATENCY=4 instance
      for (int v = 0; v < 14; v++) begin
         e = model_access(1, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
         do_req(1, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb,
                {vecs[v].exp_err, vecs[v].exp_rdata});
      end

      // Response hold with rsp_ready low, request pulses ignored
      wait_idle(0);
      push_exp(0, {1'b0, 32'd42});
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'd4;
      req_wstrb[0] = 4'h0;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'd0;
      req_wdata[0] = 32'hFFFFFFFF;
      req_wstrb[0] = 4'hF;
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         check("hold_rsp_valid", {32'h0, rsp_valid[0]}, 33'h1);
         check("hold_rsp_rdata", {1'b0, rsp_rdata[0]}, 33'd42);
         check("hold_req_ready", {32'h0, req_ready[0]}, 33'h0);
         @(posedge clk);
         #1;
         req_valid[0] = (h % 2 == 0);
      end
      req_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("after_hs_req_ready", {32'h0, req_ready[0]}, 33'h1);
      check("after_hs_rsp_valid", {32'h0, rsp_valid[0]}, 33'h0);
      check("after_hs_rdata_kept", {1'b0, rsp_rdata[0]}, 33'd42);
      do_req(0, 1'b0, 32'd0, 32'h0, 4'h0, model_access(0, 1'b0, 32'd0, 32'h0, 4'h0));

      // Reset during the second WAIT cycle drops the write
      wait_idle(1);
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'd0;
      req_wdata[1] = 32'd5;
      req_wstrb[1] = 4'hF;
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_reset_ready", {32'h0, req_ready[1]}, 33'h1);
      for (int i = 0; i < 6; i++) begin
         check("mid_reset_no_rsp", {32'h0, rsp_valid[1]}, 33'h0);
         @(negedge clk);
      end
      do_req(1, 1'b0, 32'd0, 32'h0, 4'h0, model_access(1, 1'b0, 32'd0, 32'h0, 4'h0));

      // Random traffic against the model
      for (int n = 0; n < 40; n++) begin
         int d;
         d     = n % 2;
         we    = 1'($urandom_range(0, 1));
         addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) addr = addr + 32'(4 * DEPTH);
         wdata = $urandom;
         wstrb = 4'($urandom_range(0, 15));
         e = model_access(d, we, addr, wdata, wstrb);
         do_req(d, we, addr, wdata, wstrb, e);
         if (we && !e[32]) begin
            e = model_access(d, 1'b0, addr, 32'h0, 4'h0);
            do_req(d, 1'b0, addr, 32'h0, 4'h0, e);
         end
      end

      wait_idle(0);
      wait_idle(1);
      repeat (3) @(negedge clk);
      check("queue0_drained", 33'(exp_q0.size()), 33'h0);
      check("queue1_drained", 33'(exp_q1.size()), 33'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mem_responder
